sprot_mc: RTL

Multi-channel, parametrised protocol checker for the start/phase handshake family. Each of `NUM_CH` independent channels watches a `start` strobe followed by a sequence of `SEQ_LEN` phase strobes, each of which must arrive within `MAX_WAIT` cycles of the previous event. Every channel reports a one-cycle `xfer_end` or `prot_err` pulse with an error cause. Shared saturating counters track completed and failed transfers. The block sits beside the protocol bus as a passive monitor and drives no bus signals.

---
 rtl/sprot_mc.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sprot_mc.sv
`default_nettype none
// ============================================================================
// sprot_mc : passive multi-channel start/phase handshake protocol checker
// Rev 1.0  : initial release
// ============================================================================
module sprot_mc #(
  parameter int NUM_CH   = 4,
  parameter int SEQ_LEN  = 2,
  parameter int MAX_WAIT = 1,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     start,
  input  logic [NUM_CH*SEQ_LEN-1:0] ph,
  input  logic                  clr_cnt,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     xfer_end,
  output logic [NUM_CH-1:0]     prot_err,
  output logic [2*NUM_CH-1:0]   err_cause,
  output logic [CNT_W-1:0]      xfer_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int WT_W  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int POP_W = $clog2(NUM_CH + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(SEQ_LEN - 1);
  localparam logic [WT_W-1:0]  c_last_wt   = WT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [1:0]       c_cause_wrong   = 2'b01;
  localparam logic [1:0]       c_cause_timeout = 2'b10;
  localparam logic [1:0]       c_cause_overlap = 2'b11;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PHASE = 1'b1} state_t;

  logic [NUM_CH-1:0] w_good;
  logic [NUM_CH-1:0] w_bad;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t             r_st;
    logic [IDX_W-1:0]   r_idx;
    logic [WT_W-1:0]    r_wt;
    logic               r_end;
    logic               r_err;
    logic [1:0]         r_cause;
    logic [SEQ_LEN-1:0] w_v;
    logic [SEQ_LEN-1:0] w_exp;
    logic               w_good_c;
    logic               w_bad_c;
    logic [1:0]         w_cause;

    assign w_v   = ph[c*SEQ_LEN +: SEQ_LEN];
    assign w_exp = SEQ_LEN'(1) << r_idx;

    // Outcome of this edge, in the checker's priority order.
    always_comb begin
      w_good_c = 1'b0;
      w_bad_c  = 1'b0;
      w_cause  = 2'b00;
      if (r_st == ST_PHASE) begin
        if (start[c]) begin
          w_bad_c = 1'b1;
          w_cause = c_cause_overlap;
        end else if (w_v == w_exp) begin
          w_good_c = (r_idx == c_last_idx);
        end else if (w_v != '0) begin
          w_bad_c = 1'b1;
          w_cause = c_cause_wrong;
        end else if (r_wt == c_last_wt) begin
          w_bad_c = 1'b1;
          w_cause = c_cause_timeout;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_st    <= ST_IDLE;
        r_idx   <= '0;
        r_wt    <= '0;
        r_end   <= 1'b0;
        r_err   <= 1'b0;
        r_cause <= 2'b00;
      end else begin
        r_end   <= w_good_c | w_bad_c;
        r_err   <= w_bad_c;
        r_cause <= w_cause;
        if (r_st == ST_IDLE) begin
          if (start[c]) begin
            r_st  <= ST_PHASE;
            r_idx <= '0;
            r_wt  <= '0;
          end
        end else if (w_good_c || w_bad_c) begin
          r_st  <= ST_IDLE;
          r_idx <= '0;
          r_wt  <= '0;
        end else if (w_v == w_exp) begin
          r_idx <= r_idx + IDX_W'(1);
          r_wt  <= '0;
        end else begin
          r_wt  <= r_wt + WT_W'(1);
        end
      end
    end

    assign w_good[c]            = w_good_c;
    assign w_bad[c]             = w_bad_c;
    assign busy[c]              = (r_st == ST_PHASE);
    assign xfer_end[c]          = r_end;
    assign prot_err[c]          = r_err;
    assign err_cause[2*c +: 2]  = r_cause;
  end

  logic [POP_W-1:0] w_n_good;
  logic [POP_W-1:0] w_n_bad;
  logic [SUM_W-1:0] w_xsum;
  logic [SUM_W-1:0] w_esum;
  logic [CNT_W-1:0] r_xcnt;
  logic [CNT_W-1:0] r_ecnt;

  always_comb begin
    w_n_good = '0;
    w_n_bad  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_n_good = w_n_good + POP_W'(w_good[i]);
      w_n_bad  = w_n_bad  + POP_W'(w_bad[i]);
    end
  end

  // Extra headroom bit lets the sum overflow be detected before clamping.
  assign w_xsum = SUM_W'(r_xcnt) + SUM_W'(w_n_good);
  assign w_esum = SUM_W'(r_ecnt) + SUM_W'(w_n_bad);

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      r_xcnt <= '0;
      r_ecnt <= '0;
    end else begin
      r_xcnt <= (w_xsum > SUM_W'(c_cnt_max)) ? c_cnt_max : CNT_W'(w_xsum);
      r_ecnt <= (w_esum > SUM_W'(c_cnt_max)) ? c_cnt_max : CNT_W'(w_esum);
    end
  end

  assign xfer_cnt = r_xcnt;
  assign err_cnt  = r_ecnt;

endmodule
`default_nettype wire
